// File: rtl/riscv_pkg.sv
// Shared register-file geometry and the writeback payload type used by the
// writeback unit and its LSU result queue.
package riscv_pkg;

    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LSU  = 2'd2
    } wb_sel_e;

    // x0 is hardwired to zero, so results aimed at it are dropped.
    function automatic logic is_x0(input logic [REG_AW-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries that buffers load results while the
// ALU owns the regfile write port. DEPTH must be a power of two.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: payload storage has no reset; count and pointers alone decide
    // validity, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: arbitrates ALU and buffered LSU results onto the single
// regfile write port and tracks per-register busy state for hazard detection.
module wb_unit
    import riscv_pkg::*;
#(
    parameter int LSU_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1addr,
    input  logic [REG_AW-1:0] rs2addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              stall_req,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    output logic              wren
);

    localparam int CNT_W = $clog2(LSU_DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT - 1);

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    wb_entry_t        fifo_head;
    wb_entry_t        lsu_entry;
    logic [CNT_W-1:0] fifo_count;

    wb_sel_e          sel;
    logic             alu_take;

    wb_entry_t        wr_q, wr_d;
    logic             wren_q, wren_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             stall_q, stall_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Ready looks only at occupancy, never at a same-cycle pop.
    assign lsu_ready = (fifo_count < CNT_W'(LSU_DEPTH));
    assign fifo_push = lsu_valid && lsu_ready && !is_x0(lsu_rd);
    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
    assign alu_take  = alu_valid && !is_x0(alu_rd);
    assign fifo_pop  = (sel == SEL_LSU);

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_lsu_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (fifo_push),
        .din   (lsu_entry),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .count (fifo_count)
    );

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel    = SEL_NONE;
        wr_d   = wr_q;
        wren_d = 1'b0;
        if (alu_take) begin
            sel    = SEL_ALU;
            wr_d   = '{rd: alu_rd, data: alu_data};
            wren_d = 1'b1;
        end else if (!fifo_empty) begin
            sel    = SEL_LSU;
            wr_d   = fifo_head;
            wren_d = 1'b1;
        end
    end

    // Age of the FIFO head; saturates once it reaches the stall threshold.
    always_comb begin
        age_d = age_q;
        if (fifo_empty || fifo_pop) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
        end
        stall_d = !fifo_empty && !fifo_pop && (age_q >= AGE_MAX);
    end

    // Clear for the landing write first, so a same-cycle issue to the same
    // register leaves it busy for the newer instruction.
    always_comb begin
        busy_d = busy_q;
        if (wren_q) begin
            busy_d[wr_q.rd] = 1'b0;
        end
        if (issue_valid && !is_x0(issue_rd)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q    <= '0;
            wren_q  <= 1'b0;
            age_q   <= '0;
            stall_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            wren_q  <= wren_d;
            age_q   <= age_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
        end
    end

    assign waddr     = wr_q.rd;
    assign wdata     = wr_q.data;
    assign wren      = wren_q;
    assign stall_req = stall_q;
    assign rs1_busy  = busy_q[rs1addr];
    assign rs2_busy  = busy_q[rs2addr];

endmodule
